// File: rtl/lane_serializer_pkg.sv
// Shared definitions for the lane serializer and the adder-tree levels that
// use the same packed multi-lane word layout.
package lane_serializer_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Lane index width: never narrower than one bit, even for a single lane.
  function automatic int idx_width(input int num_lanes);
    return (clog2(num_lanes) < 1) ? 1 : clog2(num_lanes);
  endfunction

  // Packed-word layout: lane k occupies bits [k*lane_width +: lane_width].
  // Every block that packs or unpacks lanes uses this to agree on the order.
  function automatic int lane_lsb(input int k, input int lane_width);
    return k * lane_width;
  endfunction

  // Serializer FSM encoding.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_serializer_if.sv
// Input word stream plus output lane stream of the lane serializer.
// slave is the serializer's view, master is the view of whoever drives it.
interface lane_serializer_if #(
  parameter int LANE_WIDTH = 3,
  parameter int NUM_LANES  = 4
);
  localparam int DIN_WIDTH = NUM_LANES * LANE_WIDTH;
  localparam int IDX_WIDTH = lane_serializer_pkg::idx_width(NUM_LANES);

  logic                 s_valid;
  logic                 s_ready;
  logic [DIN_WIDTH-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [LANE_WIDTH-1:0] m_data;
  logic [IDX_WIDTH-1:0] m_idx;
  logic                 m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_idx, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_idx, m_last
  );
endinterface

// File: rtl/lane_serializer_lane_select.sv
// Combinational NUM_LANES:1 selector of one LANE_WIDTH lane from a packed word.
module lane_select
  import lane_serializer_pkg::*;
#(
  parameter int LANE_WIDTH = 3,
  parameter int NUM_LANES  = 4,
  parameter int IDX_WIDTH  = idx_width(NUM_LANES)
) (
  input  logic [NUM_LANES*LANE_WIDTH-1:0] lanes,
  input  logic [IDX_WIDTH-1:0]            idx,
  output logic [LANE_WIDTH-1:0]           lane
);

  // Pick lane idx; unreachable idx codes fall back to zero.
  always_comb begin
    lane = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (idx == IDX_WIDTH'(k)) lane = lanes[lane_lsb(k, LANE_WIDTH) +: LANE_WIDTH];
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// Unpacks one packed NUM_LANES-lane word into NUM_LANES output beats,
// lane 0 first, with lane index and last flag. A new word is taken in the
// same cycle the last lane leaves, so back-to-back words have no bubble.
// Note for integrators: in SEND, s_ready is combinational from m_ready.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter  int LANE_WIDTH = 3,
  parameter  int NUM_LANES  = 4,
  localparam int DIN_WIDTH  = NUM_LANES * LANE_WIDTH,
  localparam int IDX_WIDTH  = idx_width(NUM_LANES)
) (
  input  logic clk,
  input  logic rst_n,
  lane_serializer_if.slave bus
);

  if (NUM_LANES < 1) begin : g_bad_lanes
    $fatal(1, "lane_serializer: NUM_LANES must be >= 1");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_LANES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DIN_WIDTH-1:0]  buffer;
  logic [IDX_WIDTH-1:0]  idx;
  logic [LANE_WIDTH-1:0] lane;
  logic                  is_last;
  logic                  load;
  logic                  advance;
  logic                  ready;
  logic                  valid;
  logic                  last;

  assign is_last = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake outputs and buffer/index control.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    ready     = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        last  = is_last;
        ready = bus.m_ready && is_last;
        if (bus.m_ready) begin
          if (!is_last)         advance   = 1'b1;
          else if (bus.s_valid) load      = 1'b1;
          else                  state_nxt = IDLE;
        end
      end
    endcase
  end

  // Word buffer and lane counter; a load always restarts at lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      idx    <= '0;
    end else if (load) begin
      buffer <= bus.s_data;
      idx    <= '0;
    end else if (advance) begin
      idx    <= idx + IDX_WIDTH'(1);
    end
  end

  lane_select #(
    .LANE_WIDTH (LANE_WIDTH),
    .NUM_LANES  (NUM_LANES),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_lane_select (
    .lanes (buffer),
    .idx   (idx),
    .lane  (lane)
  );

  assign bus.s_ready = rst_n && ready;
  assign bus.m_valid = valid;
  assign bus.m_last  = last;
  assign bus.m_data  = lane;
  assign bus.m_idx   = idx;

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Streaming unpacker for the packed multi-lane format consumed by the adder-tree levels.
- Accepts one packed word of NUM_LANES lanes, each LANE_WIDTH bits, over a valid/ready input.
- Emits the lanes one per beat over a valid/ready output, tagged with lane index and a last flag.
- Used where lane values must be inspected, stored or re-reduced serially instead of through the parallel tree.

Parameters:
- LANE_WIDTH, 3, bit width of one lane.
- NUM_LANES, 4, lanes per packed input word; must be >= 1, elaboration-time fatal otherwise.
- DIN_WIDTH, NUM_LANES*LANE_WIDTH, packed input width; derived, do not override.
- IDX_WIDTH, max(1, clog2(NUM_LANES)), lane index width; derived.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  DIN_WIDTH  packed word; lane k occupies bits [k*LANE_WIDTH +: LANE_WIDTH].
- m_valid  output  1  output lane valid.
- m_ready  input  1  downstream accepts the lane.
- m_data  output  LANE_WIDTH  current lane value.
- m_idx  output  IDX_WIDTH  index of the current lane.
- m_last  output  1  high when m_idx == NUM_LANES-1.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset state:
  - state = IDLE; word buffer, idx, m_data and m_idx = 0; m_valid = 0; m_last = 0.
  - s_ready is forced 0 while rst_n is low.
- Handshakes:
  - Input beat = s_valid && s_ready. Output beat = m_valid && m_ready.
  - Standard valid/ready rules: once asserted, m_valid stays high and m_data/m_idx/m_last stay stable until the output beat.
- State IDLE:
  - m_valid = 0; s_ready = 1.
  - On an input beat: capture s_data into the buffer, set idx = 0, go to SEND.
- State SEND:
  - m_valid = 1; m_data = buffer lane idx; m_idx = idx; m_last = (idx == NUM_LANES-1).
  - Output beat with m_last = 0: idx increments by 1.
  - Output beat with m_last = 1 and no input beat in the same cycle: go to IDLE.
- Back-to-back words:
  - In SEND, s_ready = m_ready && m_last. This is a combinational path from m_ready, and it is documented for integrators.
  - If the last-lane output beat and an input beat happen in the same cycle: load the new word, idx = 0, stay in SEND with no bubble.
- Latency and throughput:
  - The first lane is presented the cycle after the input beat.
  - Sustained throughput is one lane per cycle, i.e. NUM_LANES cycles per word.
- m_data is a mux of the registered buffer by the registered idx. It has no combinational path from s_data.
- Lane order is ascending, lane 0 first, matching the adder-level pairing order.
- idx never exceeds NUM_LANES-1, so no wrap beyond range. For a non-power-of-2 NUM_LANES, the unused idx codes are unreachable.
- NUM_LANES == 1: every word is a single beat with m_last = 1 and m_idx = 0.
- Downstream stall (m_ready low): lane held indefinitely, s_ready = 0, no loss.
- Reset asserted mid-word: the partial word is dropped and no further lanes are emitted. After release the block is in IDLE.

Decomposition:
- Shared package:
  - clog2 function.
  - State encoding constants IDLE/SEND, 1-bit.
  - The lane-slice index convention (k*LANE_WIDTH) as a documented constant expression, so adder levels and this block agree.
- One natural sub-module: lane_select, a combinational NUM_LANES:1 mux of LANE_WIDTH lanes indexed by idx.
- The FSM, counter and buffer stay in lane_serializer.

Test Plan:
- Reset, then a single word s_data=12'b101_011_110_001 with m_ready=1 -> lanes 1,6,3,5 on consecutive cycles starting 1 cycle after accept; m_idx 0..3; m_last only on 5.
- Two words presented back-to-back with m_ready=1 -> 8 consecutive lane beats, no gap; s_ready pulses high exactly on each last-lane beat.
- m_ready held low 5 cycles during lane 2 -> m_data, m_idx=2 and m_valid stable; s_ready=0; the sequence resumes with no lane lost or duplicated.
- rst_n pulsed low while emitting lane 1 -> m_valid=0 immediately (asynchronous); after release s_ready=1, and a fresh word starts at m_idx=0.
- NUM_LANES=1, LANE_WIDTH=5, words 7,31 back-to-back -> one beat each, m_last=1, m_idx=0, s_ready=m_ready.
- NUM_LANES=3 (non-power-of-2), random data and random m_ready -> a scoreboard matches lanes in order; m_idx never equals 3.
